// File: rtl/button_event_pkg.sv
// button_event shared definitions: FSM state codes and counter sizing.
package button_event_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    function automatic int cnt_w(input int long_n, input int repeat_n);
        int w;
        w = $clog2(long_n);
        if ($clog2(repeat_n) > w) w = $clog2(repeat_n);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/button_event_ch.sv
// One button channel: press/release/long/repeat pulse generator.
module button_event_ch
    import button_event_pkg::*;
#(
    parameter int LONG_N   = 50000000,
    parameter int REPEAT_N = 10000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int CW = cnt_w(LONG_N, REPEAT_N);
    localparam logic [CW-1:0] LONG_T = CW'(LONG_N - 1);
    localparam logic [CW-1:0] REP_T =
        (REPEAT_N == 0) ? '0 : CW'(REPEAT_N - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic press_q, press_d;
    logic rel_q, rel_d;
    logic long_q, long_d;
    logic rep_q, rep_d;
    logic held_q, held_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_i) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESS: begin
                if (!btn_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (cnt_q == LONG_T) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                // Release takes priority over a coincident repeat.
                if (!btn_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (REPEAT_N != 0) begin
                    if (cnt_q == REP_T) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESS) || (state_d == HOLD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;
    assign repeat_o  = rep_q;
    assign held_o    = held_q;

endmodule

// File: rtl/button_event.sv
// Multi-channel button event generator; one independent
// button_event_ch per debounced input bit.
module button_event
    import button_event_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int LONG_N   = 50000000,
    parameter int REPEAT_N = 10000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_event_ch #(
            .LONG_N  (LONG_N),
            .REPEAT_N(REPEAT_N)
        ) u_ch (
            .clk_i    (sys_clk),
            .rst_ni   (sys_rst_n),
            .btn_i    (debounced[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .long_o   (long_pulse[i]),
            .repeat_o (repeat_pulse[i]),
            .held_o   (held[i])
        );
    end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: expected pulse vectors are
// derived from the stimulus timing and compared each cycle.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;

    typedef struct packed {
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
        logic [1:0] rp;
        logic [1:0] hd;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] din = 2'b00;

    logic [1:0] pa, ra, la, rpa, ha;
    logic [1:0] pb, rb, lb, rpb, hb;
    ev_t oa, ob;
    ev_t qa[$];
    ev_t qb[$];

    int checks = 0;
    int errors = 0;
    int nlong_b = 0;
    int nrep_b = 0;
    int npr_b = 0;
    int nrl_b = 0;

    assign oa = {pa, ra, la, rpa, ha};
    assign ob = {pb, rb, lb, rpb, hb};

    always #5 clk = ~clk;

    button_event #(.WIDTH(2), .LONG_N(L), .REPEAT_N(R)) u_a (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .debounced    (din),
        .press_pulse  (pa),
        .release_pulse(ra),
        .long_pulse   (la),
        .repeat_pulse (rpa),
        .held         (ha)
    );

    button_event #(.WIDTH(2), .LONG_N(L), .REPEAT_N(0)) u_b (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .debounced    (din),
        .press_pulse  (pb),
        .release_pulse(rb),
        .long_pulse   (lb),
        .repeat_pulse (rpb),
        .held         (hb)
    );

    // {press, release, long, repeat, held} after edge c for a press
    // first sampled at edge s and held high for h edges.
    function automatic logic [4:0] ch_exp(int c, int s, int h, int rep);
        logic p, rl, lg, rp, hd;
        if (h <= 0) return 5'b0;
        p  = (c == s);
        rl = (c == s + h);
        hd = (c >= s) && (c < s + h);
        lg = (c == s + L) && (c < s + h);
        rp = (rep != 0) && (c > s + L) && (c < s + h)
             && (((c - s - L) % rep) == 0);
        return {p, rl, lg, rp, hd};
    endfunction

    function automatic ev_t mk(logic [4:0] e1, logic [4:0] e0);
        ev_t e;
        e.pr = {e1[4], e0[4]};
        e.rl = {e1[3], e0[3]};
        e.lg = {e1[2], e0[2]};
        e.rp = {e1[1], e0[1]};
        e.hd = {e1[0], e0[0]};
        return e;
    endfunction

    task automatic run_pat(input string tag, input int s0, input int h0,
                           input int s1, input int h1, input int n);
        ev_t ea, eb;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            din[0] = (h0 > 0) && (c >= s0) && (c < s0 + h0);
            din[1] = (h1 > 0) && (c >= s1) && (c < s1 + h1);
            qa.push_back(mk(ch_exp(c, s1, h1, R), ch_exp(c, s0, h0, R)));
            qb.push_back(mk(ch_exp(c, s1, h1, 0), ch_exp(c, s0, h0, 0)));
            @(posedge clk);
            #1;
            ea = qa.pop_front();
            eb = qb.pop_front();
            checks++;
            if (oa !== ea) begin
                errors++;
                $display("FAIL %s A cyc %0d got %b exp %b", tag, c, oa, ea);
            end
            checks++;
            if (ob !== eb) begin
                errors++;
                $display("FAIL %s B cyc %0d got %b exp %b", tag, c, ob, eb);
            end
            nlong_b += $countones(lb);
            nrep_b  += $countones(rpb);
            npr_b   += $countones(pb);
            nrl_b   += $countones(rb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 2'b00;
        #1;
        checks++;
        if ({oa, ob} !== '0) begin
            errors++;
            $display("FAIL reset got %b %b exp 0", oa, ob);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_short();
        run_pat("short", 0, 3, 0, 0, 7);
    endtask

    task automatic test_long();
        run_pat("long", 0, 20, 0, 0, 24);
    endtask

    task automatic test_collision();
        run_pat("collide", 0, L, 0, 0, L + 3);
    endtask

    task automatic test_indep();
        run_pat("indep", 0, 12, 3, 12, 18);
    endtask

    task automatic test_back_to_back();
        run_pat("b2b_a", 0, 1, 0, 0, 2);
        run_pat("b2b_b", 0, 2, 0, 0, 4);
    endtask

    task automatic test_reset_mid();
        run_pat("rmid_pre", 0, 1000, 0, 0, 11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({oa, ob} !== '0) begin
            errors++;
            $display("FAIL rmid_async got %b %b exp 0", oa, ob);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if ({oa, ob} !== '0) begin
                errors++;
                $display("FAIL rmid_hold got %b %b exp 0", oa, ob);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (oa !== mk(5'b0, 5'b10001) || ob !== mk(5'b0, 5'b10001)) begin
            errors++;
            $display("FAIL rmid_press got %b %b exp %b", oa, ob,
                     mk(5'b0, 5'b10001));
        end
        run_pat("rmid_post", -1, 4, 0, 0, 6);
    endtask

    task automatic test_no_repeat();
        nlong_b = 0;
        nrep_b  = 0;
        npr_b   = 0;
        nrl_b   = 0;
        run_pat("norep", 0, 30, 0, 0, 34);
        checks++;
        if (nrep_b != 0 || nlong_b != 1 || npr_b != 1 || nrl_b != 1) begin
            errors++;
            $display("FAIL norep_cnt got rep %0d long %0d pr %0d rl %0d exp 0 1 1 1",
                     nrep_b, nlong_b, npr_b, nrl_b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short();
        test_long();
        test_collision();
        test_indep();
        test_back_to_back();
        test_reset_mid();
        test_no_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumer end of the button-conditioning path: takes clean levels from the debouncer and converts each channel into one-cycle event pulses.
- Events per channel: press, release, long-press and auto-repeat.
- Sits between the debounced push-button bus and game/menu control logic, which then needs no edge or timing logic of its own.
- All channels are independent and identical.

Parameters:
- WIDTH, 1, number of independent button channels.
- LONG_N, 50000000, cycles from press pulse to long pulse; legal range ≥ 2.
- REPEAT_N, 10000000, cycles between successive repeat pulses after long; 0 disables repeat; otherwise ≥ 2.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- debounced  input  WIDTH  clean button levels, synchronous to sys_clk (1 = pressed).
- press_pulse  output  WIDTH  one-cycle pulse per channel on press.
- release_pulse  output  WIDTH  one-cycle pulse per channel on release.
- long_pulse  output  WIDTH  one-cycle pulse when held for LONG_N cycles.
- repeat_pulse  output  WIDTH  one-cycle pulse every REPEAT_N cycles after long.
- held  output  WIDTH  level; 1 while the channel is in PRESS or HOLD.

Behaviour:
- One clock (sys_clk). Reset is asynchronous, active-low (sys_rst_n).
- Reset values:
  - state = IDLE and cnt = 0 in every channel.
  - All outputs = 0.
- All outputs are registered. Each pulse is exactly 1 cycle wide.
- Per-channel FSM states: IDLE, PRESS, HOLD. The channel counter is width $clog2(max(LONG_N, REPEAT_N, 2)), unsigned, and never wraps past its terminal value.
- IDLE:
  - On an edge with debounced = 1: go to PRESS, cnt <= 0, press_pulse = 1 in the following cycle.
  - Otherwise stay in IDLE.
- PRESS:
  - On an edge with debounced = 0: go to IDLE, cnt <= 0, release_pulse = 1.
  - Else if cnt == LONG_N-1: go to HOLD, cnt <= 0, long_pulse = 1.
  - Else cnt <= cnt+1.
  - Result: long_pulse rises exactly LONG_N cycles after press_pulse.
- HOLD:
  - On an edge with debounced = 0: go to IDLE, cnt <= 0, release_pulse = 1.
  - Else if REPEAT_N != 0 and cnt == REPEAT_N-1: cnt <= 0, repeat_pulse = 1.
  - Else if REPEAT_N != 0: cnt <= cnt+1.
  - With REPEAT_N == 0, cnt holds at 0.
- held = 1 in PRESS or HOLD. It is registered, so it rises in the same cycle as press_pulse and falls in the same cycle as release_pulse.
- Simultaneous events:
  - Release wins over long and over repeat on the same edge; only release_pulse fires.
  - Channels never interact. Any combination of pulses on different bits may occur in the same cycle.
- Minimum gaps:
  - A press lasting one cycle gives press_pulse, then release_pulse on the next cycle.
  - A re-press immediately after release (one low cycle) gives a new press_pulse one cycle after release_pulse.
- Reset mid-operation:
  - Reset forces IDLE, clears counters and drops all outputs immediately (asynchronous).
  - No release_pulse is generated for a channel that was held when reset asserted.
  - A button still high after reset release produces press_pulse on the first active edge.
- No events are ever lost or doubled for an input that changes at most once per cycle.

Decomposition:
- Package button_event_pkg holds:
  - The state encoding constants IDLE = 2'd0, PRESS = 2'd1, HOLD = 2'd2.
  - A counter-width function that returns max($clog2(LONG_N), $clog2(REPEAT_N), 1).
- Sub-module button_event_ch: one channel (FSM, counter, four pulse registers and held).
- button_event instantiates button_event_ch WIDTH times via a generate loop, passing LONG_N and REPEAT_N.

Test Plan (WIDTH=2, LONG_N=8, REPEAT_N=4 unless noted):
1. Short press: debounced[0] high for 3 cycles, sampled at edge 0 -> press_pulse[0] in cycle 1, release_pulse[0] in cycle 4; no long_pulse; held[0] high in cycles 1-3.
2. Long hold: debounced[0] high for 20 cycles -> press at cycle 1, long at cycle 9, repeat at cycles 13 and 17, release at cycle 21.
3. Release collision: debounced[0] high for exactly 8 cycles, so the fall coincides with the long-count edge -> release_pulse[0] only; no long_pulse[0].
4. Independent channels: bit0 pressed at cycle 0, bit1 pressed at cycle 3, both held 12 cycles -> press[1:0] at 1 and 4, long at 9 and 12; no cross-talk.
5. Reset mid-HOLD: assert sys_rst_n low at cycle 11 while debounced[0] = 1, release reset 2 cycles later -> all outputs 0 during reset, no release_pulse, press_pulse[0] on the first cycle after reset.
6. REPEAT_N=0: hold 30 cycles -> exactly one press, one long and one release; zero repeat_pulse.
